// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the 4 KB data memory: grants one port, latches its
// command and runs a single memory access per grant, returning data/status to that port.
module dm_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_byte,
    input  logic          p0_sgn,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_done,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_stall,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_byte,
    input  logic          p1_sgn,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_done,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic          busy,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          mem_byte,
    output logic          mem_sig,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam bit RR_EN = (RR != 0);

    state_t        state_reg;
    logic          last_reg;
    logic          cmd_we_reg;
    logic          cmd_byte_reg;
    logic          cmd_sgn_reg;
    logic          cmd_port_reg;
    logic          cmd_err_reg;
    logic [AW-1:0] cmd_addr_reg;
    logic [DW-1:0] cmd_wdata_reg;

    logic          grant;
    logic          sel_we;
    logic          sel_byte;
    logic          sel_sgn;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_misaligned;
    logic          access;

    always_comb begin
        grant = 1'b0;
        if (RR_EN) begin
            if (p0_req && p1_req)
                grant = ~last_reg;
            else
                grant = p1_req;
        end else begin
            grant = ~p0_req;
        end
    end

    assign sel_we         = grant ? p1_we    : p0_we;
    assign sel_byte       = grant ? p1_byte  : p0_byte;
    assign sel_sgn        = grant ? p1_sgn   : p0_sgn;
    assign sel_addr       = grant ? p1_addr  : p0_addr;
    assign sel_wdata      = grant ? p1_wdata : p0_wdata;
    assign sel_misaligned = ~sel_byte && (sel_addr[1:0] != 2'b00);

    // Misaligned commands still occupy the ACCESS slot (with strobes held off)
    // so every grant completes with the same two-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            cmd_we_reg    <= 1'b0;
            cmd_byte_reg  <= 1'b0;
            cmd_sgn_reg   <= 1'b0;
            cmd_port_reg  <= 1'b0;
            cmd_err_reg   <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        cmd_we_reg    <= sel_we;
                        cmd_byte_reg  <= sel_byte;
                        cmd_sgn_reg   <= sel_sgn;
                        cmd_addr_reg  <= sel_addr;
                        cmd_wdata_reg <= sel_wdata;
                        cmd_port_reg  <= grant;
                        cmd_err_reg   <= sel_misaligned;
                        last_reg      <= grant;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS:  state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic          done_reg;
            logic          err_reg;
            logic [DW-1:0] rdata_reg;
            logic          hit;

            assign hit = (state_reg == ACCESS) && (cmd_port_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= hit;
                    err_reg  <= hit && cmd_err_reg;
                    if (hit && cmd_err_reg)
                        rdata_reg <= '0;
                    else if (hit && !cmd_we_reg)
                        rdata_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign p0_done  = g_port[0].done_reg;
    assign p0_err   = g_port[0].err_reg;
    assign p0_rdata = g_port[0].rdata_reg;
    assign p1_done  = g_port[1].done_reg;
    assign p1_err   = g_port[1].err_reg;
    assign p1_rdata = g_port[1].rdata_reg;

    assign p0_stall = p0_req & ~p0_done;
    assign busy     = (state_reg != IDLE);

    // rst gates the write strobe directly so a reset mid-access leaves memory untouched.
    assign access    = (state_reg == ACCESS) && !cmd_err_reg;
    assign mem_rd    = access & ~cmd_we_reg;
    assign mem_wr    = access & cmd_we_reg & ~rst;
    assign mem_byte  = cmd_byte_reg;
    assign mem_sig   = cmd_sgn_reg;
    assign mem_addr  = cmd_addr_reg;
    assign mem_wdata = cmd_wdata_reg;

endmodule
